// File: rtl/rupd_boot_sequencer_if.sv
// rupd_boot_sequencer_if
//   User-side bus of the remote-update register block. The sequencer is
//   the only master on this bus.
//
//   BUS_ADDR      master->slave  register select (0 = write data, 1 = control)
//   BUS_DATA_OUT  master->slave  write data
//   BUS_CEb       master->slave  chip enable, active-low
//   BUS_WEb       master->slave  write enable, active-low
//   BUS_DATA_IN   slave->master  status word: [31]=BUSY, [23:16]=pending
//                                control, [11:0]=data out
interface rupd_boot_sequencer_if;
  logic [1:0]  BUS_ADDR;
  logic [31:0] BUS_DATA_OUT;
  logic        BUS_CEb;
  logic        BUS_WEb;
  logic [31:0] BUS_DATA_IN;

  modport master (
    output BUS_ADDR,
    output BUS_DATA_OUT,
    output BUS_CEb,
    output BUS_WEb,
    input  BUS_DATA_IN
  );

  modport slave (
    input  BUS_ADDR,
    input  BUS_DATA_OUT,
    input  BUS_CEb,
    input  BUS_WEb,
    output BUS_DATA_IN
  );
endinterface

// File: rtl/rupd_boot_sequencer.sv
// rupd_boot_sequencer
//   Autonomous controller for the remote-update register interface.
//   START_BOOT runs: W(0,4), W(4,PGM), W(5,1), RECONFIGURE.
//   START_READ runs: R(5) and returns the 12-bit result on RD_DATA.
//   Every non-RECONF command is a data write (addr 0) followed by a control
//   write (addr 1), a fixed settle wait, then polling of the status word
//   until BUSY and the pending control byte are both clear.
//
//   CLK          in   system clock (same as the remote-update interface)
//   RESETb       in   asynchronous active-low reset
//   START_BOOT   in   one-cycle pulse, boot to the image at PGM
//   START_READ   in   one-cycle pulse, read param 5
//   PGM          in   application start page (latched at start)
//   bus          if   remote-update user bus (master modport)
//   SEQ_BUSY     out  high from accepted start until DONE or ERROR
//   DONE         out  one-cycle pulse on successful completion
//   ERROR        out  sticky timeout flag, cleared by the next accepted start
//   RD_DATA      out  result of the last read operation
module rupd_boot_sequencer #(
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int TO_W           = 16
) (
  input  logic        CLK,
  input  logic        RESETb,
  input  logic        START_BOOT,
  input  logic        START_READ,
  input  logic [6:0]  PGM,
  rupd_boot_sequencer_if.master bus,
  output logic        SEQ_BUSY,
  output logic        DONE,
  output logic        ERROR,
  output logic [11:0] RD_DATA
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR_DATA = 3'd1;
  localparam logic [2:0] ST_WR_CTRL = 3'd2;
  localparam logic [2:0] ST_SETTLE  = 3'd3;
  localparam logic [2:0] ST_POLL    = 3'd4;
  localparam logic [2:0] ST_FINISH  = 3'd5;
  localparam logic [2:0] ST_FAIL    = 3'd6;

  localparam logic [7:0] CTRL_WRITE  = 8'h02;
  localparam logic [7:0] CTRL_READ   = 8'h01;
  localparam logic [7:0] CTRL_RECONF = 8'h80;

  logic [2:0]      state;
  logic            mode_read;
  logic [1:0]      cmd_idx;
  logic [6:0]      pgm_q;
  logic [TO_W-1:0] cnt;

  logic [31:0] cmd_data;
  logic [7:0]  cmd_ctrl;
  logic        cmd_last;
  logic        cmd_reconf;
  logic        status_done;

  // Status bits the sequencer has no use for.
  logic unused_status_bits;
  assign unused_status_bits = ^{bus.BUS_DATA_IN[30:24], bus.BUS_DATA_IN[15:12]};

  // Parameter-select word: param in [18:16], value in [11:0].
  function automatic logic [31:0] param_word(input logic [2:0] p, input logic [11:0] d);
    return {13'h0, p, 4'h0, d};
  endfunction

  assign status_done = !bus.BUS_DATA_IN[31] && (bus.BUS_DATA_IN[23:16] == 8'h00);

  // Current command decoded from the operation mode and command index.
  always_comb begin
    cmd_data   = 32'h0;
    cmd_ctrl   = 8'h00;
    cmd_last   = 1'b0;
    cmd_reconf = 1'b0;
    if (mode_read) begin
      cmd_data = param_word(3'd5, 12'h000);
      cmd_ctrl = CTRL_READ;
      cmd_last = 1'b1;
    end else begin
      case (cmd_idx)
        2'd0: begin
          cmd_data = param_word(3'd0, 12'h004);
          cmd_ctrl = CTRL_WRITE;
        end
        2'd1: begin
          cmd_data = param_word(3'd4, {5'h00, pgm_q});
          cmd_ctrl = CTRL_WRITE;
        end
        2'd2: begin
          cmd_data = param_word(3'd5, 12'h001);
          cmd_ctrl = CTRL_WRITE;
        end
        default: begin
          cmd_ctrl   = CTRL_RECONF;
          cmd_last   = 1'b1;
          cmd_reconf = 1'b1;
        end
      endcase
    end
  end

  // Sequencer. Bus strobes default high every cycle so each write lasts
  // exactly one cycle. RECONF carries no parameter data, so WR_DATA
  // issues no bus cycle for it and only the control write goes out.
  always_ff @(posedge CLK or negedge RESETb) begin
    if (!RESETb) begin
      state            <= ST_IDLE;
      mode_read        <= 1'b0;
      cmd_idx          <= 2'd0;
      pgm_q            <= 7'h00;
      cnt              <= '0;
      bus.BUS_ADDR     <= 2'd0;
      bus.BUS_DATA_OUT <= 32'h0;
      bus.BUS_CEb      <= 1'b1;
      bus.BUS_WEb      <= 1'b1;
      SEQ_BUSY         <= 1'b0;
      DONE             <= 1'b0;
      ERROR            <= 1'b0;
      RD_DATA          <= 12'h000;
    end else begin
      bus.BUS_CEb <= 1'b1;
      bus.BUS_WEb <= 1'b1;
      DONE        <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (START_BOOT || START_READ) begin
            mode_read <= !START_BOOT;
            pgm_q     <= PGM;
            cmd_idx   <= 2'd0;
            ERROR     <= 1'b0;
            SEQ_BUSY  <= 1'b1;
            state     <= ST_WR_DATA;
          end
        end
        ST_WR_DATA: begin
          if (!cmd_reconf) begin
            bus.BUS_ADDR     <= 2'd0;
            bus.BUS_DATA_OUT <= cmd_data;
            bus.BUS_CEb      <= 1'b0;
            bus.BUS_WEb      <= 1'b0;
          end
          state <= ST_WR_CTRL;
        end
        ST_WR_CTRL: begin
          bus.BUS_ADDR     <= 2'd1;
          bus.BUS_DATA_OUT <= {24'h0, cmd_ctrl};
          bus.BUS_CEb      <= 1'b0;
          bus.BUS_WEb      <= 1'b0;
          if (cmd_reconf) begin
            state <= ST_FINISH;
          end else begin
            cnt   <= TO_W'(SETTLE_CYCLES);
            state <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (cnt == '0) begin
            cnt   <= TO_W'(TIMEOUT_CYCLES);
            state <= ST_POLL;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_POLL: begin
          // Completion is checked before the timeout so a command that
          // finishes on the very last poll cycle still counts.
          if (status_done) begin
            if (mode_read) begin
              RD_DATA <= bus.BUS_DATA_IN[11:0];
            end
            cmd_idx <= cmd_idx + 2'd1;
            state   <= cmd_last ? ST_FINISH : ST_WR_DATA;
          end else if (cnt == '0) begin
            state <= ST_FAIL;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_FINISH: begin
          DONE     <= 1'b1;
          SEQ_BUSY <= 1'b0;
          state    <= ST_IDLE;
        end
        ST_FAIL: begin
          ERROR    <= 1'b1;
          SEQ_BUSY <= 1'b0;
          state    <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
